// File: rtl/fetch_thread_sched_if.sv
// FETCH request bus, decode valid/ready link and scheduler control inputs.
// The master modport is the scheduler's side; slave is the environment's side.
interface fetch_thread_sched_if;
   logic [3:0]  thread_en;
   logic        redirect_valid;
   logic [1:0]  redirect_thread;
   logic [31:0] redirect_pc;
   logic        f_enable;
   logic        write_mode;
   logic [31:0] addr;
   logic [31:0] data_i;
   logic [1:0]  thread;
   logic        f_ack;
   logic [31:0] f_data;
   logic        ir_valid;
   logic        ir_ready;
   logic [31:0] ir_data;
   logic [31:0] ir_pc;
   logic [1:0]  ir_thread;

   modport master (
      input  thread_en, redirect_valid, redirect_thread, redirect_pc, f_ack, f_data, ir_ready,
      output f_enable, write_mode, addr, data_i, thread, ir_valid, ir_data, ir_pc, ir_thread
   );

   modport slave (
      output thread_en, redirect_valid, redirect_thread, redirect_pc, f_ack, f_data, ir_ready,
      input  f_enable, write_mode, addr, data_i, thread, ir_valid, ir_data, ir_pc, ir_thread
   );
endinterface

// File: rtl/fetch_thread_sched.sv
// Per-thread PC file with round-robin thread pick, one outstanding FETCH read,
// and a single-entry valid/ready output to decode. Redirects squash stale words.
module fetch_thread_sched #(
   parameter int unsigned NTHREADS = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input logic                  clk,
   input logic                  rst_n,
   fetch_thread_sched_if.master bus
);

   typedef enum logic [1:0] {StIdle, StReq, StOut} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q [NTHREADS];
   logic [31:0] pc_d [NTHREADS];
   logic [1:0]  rr_last_q, rr_last_d;
   logic        squash_q, squash_d;
   logic        f_enable_q, f_enable_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  thread_q, thread_d;
   logic        ir_valid_q, ir_valid_d;
   logic [31:0] ir_data_q, ir_data_d;
   logic [31:0] ir_pc_q, ir_pc_d;
   logic [1:0]  ir_thread_q, ir_thread_d;

   logic        grant_valid;
   logic [1:0]  grant;
   logic [1:0]  cand;
   logic        drop;

   // Descending scan so the nearest enabled thread after rr_last wins.
   always_comb begin
      grant_valid = 1'b0;
      grant       = rr_last_q;
      cand        = rr_last_q;
      for (int i = 4; i >= 1; i--) begin
         cand = rr_last_q + 2'(i);
         if (bus.thread_en[cand]) begin
            grant_valid = 1'b1;
            grant       = cand;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_last_d   = rr_last_q;
      squash_d    = squash_q;
      f_enable_d  = f_enable_q;
      addr_d      = addr_q;
      thread_d    = thread_q;
      ir_valid_d  = ir_valid_q;
      ir_data_d   = ir_data_q;
      ir_pc_d     = ir_pc_q;
      ir_thread_d = ir_thread_q;
      for (int i = 0; i < NTHREADS; i++) pc_d[i] = pc_q[i];
      drop = squash_q || (bus.redirect_valid && bus.redirect_thread == thread_q);

      unique case (state_q)
         StIdle: begin
            if (grant_valid) begin
               thread_d   = grant;
               // Forward a same-cycle redirect so the request never uses the stale PC.
               addr_d     = (bus.redirect_valid && bus.redirect_thread == grant) ?
                            bus.redirect_pc : pc_q[grant];
               f_enable_d = 1'b1;
               rr_last_d  = grant;
               state_d    = StReq;
            end
         end
         StReq: begin
            if (bus.f_ack) begin
               f_enable_d = 1'b0;
               if (drop) begin
                  squash_d = 1'b0;
                  state_d  = StIdle;
               end else begin
                  ir_data_d       = bus.f_data;
                  ir_pc_d         = addr_q;
                  ir_thread_d     = thread_q;
                  ir_valid_d      = 1'b1;
                  pc_d[thread_q]  = addr_q + PC_STEP;
                  state_d         = StOut;
               end
            end else if (bus.redirect_valid && bus.redirect_thread == thread_q) begin
               squash_d = 1'b1;
            end
         end
         StOut: begin
            if (bus.ir_ready ||
                (bus.redirect_valid && bus.redirect_thread == ir_thread_q)) begin
               ir_valid_d = 1'b0;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (bus.redirect_valid) pc_d[bus.redirect_thread] = bus.redirect_pc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         rr_last_q   <= 2'd3;
         squash_q    <= 1'b0;
         f_enable_q  <= 1'b0;
         addr_q      <= '0;
         thread_q    <= '0;
         ir_valid_q  <= 1'b0;
         ir_data_q   <= '0;
         ir_pc_q     <= '0;
         ir_thread_q <= '0;
         for (int i = 0; i < NTHREADS; i++) pc_q[i] <= RESET_PC;
      end else begin
         state_q     <= state_d;
         rr_last_q   <= rr_last_d;
         squash_q    <= squash_d;
         f_enable_q  <= f_enable_d;
         addr_q      <= addr_d;
         thread_q    <= thread_d;
         ir_valid_q  <= ir_valid_d;
         ir_data_q   <= ir_data_d;
         ir_pc_q     <= ir_pc_d;
         ir_thread_q <= ir_thread_d;
         for (int i = 0; i < NTHREADS; i++) pc_q[i] <= pc_d[i];
      end
   end

   assign bus.f_enable   = f_enable_q;
   assign bus.write_mode = 1'b0;
   assign bus.addr       = addr_q;
   assign bus.data_i     = '0;
   assign bus.thread     = thread_q;
   assign bus.ir_valid   = ir_valid_q;
   assign bus.ir_data    = ir_data_q;
   assign bus.ir_pc      = ir_pc_q;
   assign bus.ir_thread  = ir_thread_q;

endmodule

// File: tb/tb_fetch_thread_sched.sv
// Directed bench: stimulus pushes expected requests/instructions into queues,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_fetch_thread_sched;

   typedef struct { logic [31:0] addr; logic [1:0] thread; } req_t;
   typedef struct { logic [31:0] data; logic [31:0] pc; logic [1:0] thread; } out_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   fetch_thread_sched_if bus ();

   fetch_thread_sched #(
      .NTHREADS (4),
      .RESET_PC (32'h0000_0000),
      .PC_STEP  (32'd4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   req_t        req_q [$];
   out_t        out_q [$];
   logic        f_en_prev = 1'b0;
   int          ack_delay = 0;
   int          wait_cnt = 0;
   logic [31:0] data_base = '0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   // FETCH responder: word = data_base + addr + thread.
   always begin
      @(posedge clk);
      #2;
      bus.f_ack = 1'b0;
      if (rst_n && bus.f_enable) begin
         if (wait_cnt >= ack_delay) begin
            bus.f_ack  = 1'b1;
            bus.f_data = data_base + bus.addr + 32'(bus.thread);
            wait_cnt   = 0;
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   end

   always @(negedge clk) begin
      req_t r;
      out_t o;
      if (rst_n) begin
         if (bus.f_enable && !f_en_prev && req_q.size() > 0) begin
            r = req_q.pop_front();
            chk("req_addr", bus.addr, r.addr);
            chk("req_thread", 32'(bus.thread), 32'(r.thread));
         end
         if (bus.ir_valid && out_q.size() > 0) begin
            o = out_q[0];
            if (bus.ir_ready) void'(out_q.pop_front());
            chk("ir_data", bus.ir_data, o.data);
            chk("ir_pc", bus.ir_pc, o.pc);
            chk("ir_thread", 32'(bus.ir_thread), 32'(o.thread));
         end
      end
      f_en_prev = bus.f_enable;
   end

   task automatic exp_req(input logic [31:0] a, input logic [1:0] t);
      req_t r;
      r.addr = a; r.thread = t;
      req_q.push_back(r);
   endtask

   task automatic exp_out(input logic [31:0] d, input logic [31:0] p, input logic [1:0] t);
      out_t o;
      o.data = d; o.pc = p; o.thread = t;
      out_q.push_back(o);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((req_q.size() > 0 || out_q.size() > 0) && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (req_q.size() > 0 || out_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain_%s: pending req=%0d out=%0d, want 0/0", name, req_q.size(),
                  out_q.size());
      end
      #1;
   endtask

   // which: 0 = f_enable, 1 = ir_valid.
   task automatic wait_high(input int which);
      int n = 0;
      while (n < 100) begin
         @(posedge clk);
         #1;
         if ((which == 0) ? bus.f_enable : bus.ir_valid) return;
         n++;
      end
      miscompares++;
      $display("FAIL wait_high_%0d: signal never rose, want 1", which);
   endtask

   task automatic async_reset_check(input string name);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk({name, "_f_enable"}, 32'(bus.f_enable), 32'd0);
      chk({name, "_ir_valid"}, 32'(bus.ir_valid), 32'd0);
      req_q.delete();
      out_q.delete();
   endtask

   task automatic release_reset();
      @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.thread_en      = 4'b0000;
      bus.ir_ready       = 1'b1;
      bus.redirect_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      req_q.delete();
      out_q.delete();
      release_reset();
   endtask

   task automatic redirect(input logic [1:0] t, input logic [31:0] p);
      bus.redirect_valid  = 1'b1;
      bus.redirect_thread = t;
      bus.redirect_pc     = p;
      @(posedge clk);
      #1 bus.redirect_valid = 1'b0;
   endtask

   initial begin
      bus.thread_en       = 4'b0000;
      bus.redirect_valid  = 1'b0;
      bus.redirect_thread = '0;
      bus.redirect_pc     = '0;
      bus.f_ack           = 1'b0;
      bus.f_data          = '0;
      bus.ir_ready        = 1'b1;

      #12;
      chk("rst_f_enable", 32'(bus.f_enable), 32'd0);
      chk("rst_addr", bus.addr, 32'd0);
      chk("rst_thread", 32'(bus.thread), 32'd0);
      chk("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
      chk("rst_ir_data", bus.ir_data, 32'd0);
      chk("rst_ir_pc", bus.ir_pc, 32'd0);
      chk("rst_ir_thread", 32'(bus.ir_thread), 32'd0);
      chk("write_mode", 32'(bus.write_mode), 32'd0);
      chk("data_i", bus.data_i, 32'd0);
      release_reset();

      // 1: single thread, delayed ack
      ack_delay = 2; data_base = 32'hDEAD_BEEF;
      exp_req(32'h0, 2'd0); exp_out(32'hDEAD_BEEF, 32'h0, 2'd0); exp_req(32'h4, 2'd0);
      bus.thread_en = 4'b0001;
      drain("t1");
      do_reset();

      // 2: round robin over all threads, immediate acks
      ack_delay = 0; data_base = 32'h1000_0000;
      for (int t = 0; t < 4; t++) begin
         exp_req(32'h0, 2'(t));
         exp_out(32'h1000_0000 + 32'(t), 32'h0, 2'(t));
      end
      exp_req(32'h4, 2'd0); exp_out(32'h1000_0004, 32'h4, 2'd0);
      bus.thread_en = 4'b1111;
      drain("t2");
      do_reset();

      // 3: decode backpressure
      data_base = 32'h3000_0000; bus.ir_ready = 1'b0;
      exp_req(32'h0, 2'd0); exp_out(32'h3000_0000, 32'h0, 2'd0);
      bus.thread_en = 4'b0001;
      wait_high(1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("stall_f_enable", 32'(bus.f_enable), 32'd0);
         chk("stall_ir_valid", 32'(bus.ir_valid), 32'd1);
      end
      exp_req(32'h4, 2'd0); exp_out(32'h3000_0004, 32'h4, 2'd0);
      bus.ir_ready = 1'b1;
      drain("t3");
      do_reset();

      // 4a: redirect thread 1 during a pending REQ -> squash
      ack_delay = 3; data_base = 32'h4000_0000;
      exp_req(32'h0, 2'd1); exp_req(32'h100, 2'd1); exp_out(32'h4000_0101, 32'h100, 2'd1);
      bus.thread_en = 4'b0010;
      wait_high(0);
      redirect(2'd1, 32'h100);
      drain("t4a");
      do_reset();

      // 4b: redirect coinciding with the ack -> word dropped directly
      ack_delay = 0;
      exp_req(32'h0, 2'd1); exp_req(32'h200, 2'd1); exp_out(32'h4000_0201, 32'h200, 2'd1);
      bus.thread_en = 4'b0010;
      wait_high(0);
      redirect(2'd1, 32'h200);
      drain("t4b");
      do_reset();

      // 5: PC wraps past 2^32
      data_base = 32'h5000_0000;
      redirect(2'd2, 32'hFFFF_FFFC);
      exp_req(32'hFFFF_FFFC, 2'd2); exp_out(32'h4FFF_FFFE, 32'hFFFF_FFFC, 2'd2);
      exp_req(32'h0, 2'd2); exp_out(32'h5000_0002, 32'h0, 2'd2);
      bus.thread_en = 4'b0100;
      drain("t5");
      do_reset();

      // 7: redirect while the word waits in OUT drops ir_valid without ready
      data_base = 32'h7000_0000; bus.ir_ready = 1'b0;
      exp_req(32'h0, 2'd0); exp_out(32'h7000_0000, 32'h0, 2'd0);
      bus.thread_en = 4'b0001;
      wait_high(1);
      redirect(2'd0, 32'h80);
      void'(out_q.pop_front());
      chk("out_redirect_drop", 32'(bus.ir_valid), 32'd0);
      exp_req(32'h80, 2'd0); exp_out(32'h7000_0080, 32'h80, 2'd0);
      bus.ir_ready = 1'b1;
      drain("t7");
      do_reset();

      // 6a: reset while in OUT
      data_base = 32'h6000_0000; bus.ir_ready = 1'b0;
      exp_req(32'h0, 2'd0); exp_out(32'h6000_0000, 32'h0, 2'd0);
      bus.thread_en = 4'b0001;
      wait_high(1);
      async_reset_check("rst_out");
      bus.ir_ready = 1'b1;
      exp_req(32'h0, 2'd0); exp_out(32'h6000_0000, 32'h0, 2'd0);
      release_reset();
      drain("t6a");
      do_reset();

      // 6b: reset while in REQ; rr pointer must restart at thread 0
      ack_delay = 10;
      exp_req(32'h0, 2'd0);
      bus.thread_en = 4'b0011;
      wait_high(0);
      async_reset_check("rst_req");
      ack_delay = 0;
      exp_req(32'h0, 2'd0); exp_out(32'h6000_0000, 32'h0, 2'd0);
      release_reset();
      drain("t6b");
      do_reset();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, want finish");
      $fatal(1);
   end

endmodule
